// File: rtl/mux_rr_param_if.sv
// mux_rr_param_if
//   Bundles the channel-side and output-side signals of mux_rr_param.
//   master : the block feeding channels and observing the registered output
//   slave  : the multiplexer itself
// Signals:
//   data_in   [N_CH*WIDTH]  packed channel data, channel i at [i*WIDTH +: WIDTH]
//   valid_in  [N_CH]        per-channel request
//   hold      [1]           downstream stall, freezes all registers
//   data_out  [WIDTH]       registered selected data
//   valid_out [1]           registered valid for data_out
//   sel_out   [SEL_W]       registered index of the source channel
//   grant     [N_CH]        combinational one-hot accept
interface mux_rr_param_if #(
    parameter int WIDTH = 4,
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
);
    logic [N_CH*WIDTH-1:0] data_in;
    logic [N_CH-1:0]       valid_in;
    logic                  hold;
    logic [WIDTH-1:0]      data_out;
    logic                  valid_out;
    logic [SEL_W-1:0]      sel_out;
    logic [N_CH-1:0]       grant;

    modport master (
        output data_in, valid_in, hold,
        input  data_out, valid_out, sel_out, grant
    );

    modport slave (
        input  data_in, valid_in, hold,
        output data_out, valid_out, sel_out, grant
    );
endinterface

// File: rtl/mux_rr_param.sv
// mux_rr_param
//   Registered N-channel multiplexer. Each cycle one requesting channel is
//   chosen (round-robin when MODE=0, lowest index first when MODE=1), its
//   data is registered with a valid flag and its index, and a one-hot grant
//   tells the chosen source it has been consumed. hold freezes everything.
// Ports:
//   clk      rising-edge clock
//   reset_L  asynchronous active-low reset
//   bus      mux_rr_param_if.slave (data_in, valid_in, hold in;
//            data_out, valid_out, sel_out, grant out)
module mux_rr_param #(
    parameter int WIDTH = 4,
    parameter int N_CH  = 4,
    parameter int SEL_W = 2,
    parameter int MODE  = 0
) (
    input  logic            clk,
    input  logic            reset_L,
    mux_rr_param_if.slave   bus
);

    logic [SEL_W-1:0] ptr;
    logic [WIDTH-1:0] data_p1;
    logic             vld_p1;
    logic [SEL_W-1:0] sel_p1;

    logic             found;
    int               win_i;
    logic [SEL_W-1:0] win_sel;
    logic [SEL_W-1:0] nxt_ptr;
    logic [WIDTH-1:0] win_data;
    logic [N_CH-1:0]  grant_c;

    // Round-robin scan ptr..N_CH-1, 0..ptr-1 is done as two priority
    // searches: the first requester at or above the start point, else the
    // first requester overall (the wrap-around part).
    always_comb begin
        int   start;
        logic found_hi;
        int   hi_i;
        int   lo_i;
        start    = (MODE == 1) ? 0 : int'(ptr);
        found    = 1'b0;
        found_hi = 1'b0;
        hi_i     = 0;
        lo_i     = 0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.valid_in[i] && !found) begin
                found = 1'b1;
                lo_i  = i;
            end
            if (bus.valid_in[i] && !found_hi && (i >= start)) begin
                found_hi = 1'b1;
                hi_i     = i;
            end
        end
        win_i   = found_hi ? hi_i : lo_i;
        win_sel = SEL_W'(win_i);
        nxt_ptr = (win_i == N_CH - 1) ? '0 : SEL_W'(win_i + 1);
    end

    // Only the winning channel is ever routed to the data register, and
    // only in-range channel slices are touched.
    always_comb begin
        win_data = '0;
        grant_c  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (i == win_i) begin
                win_data   = bus.data_in[i*WIDTH +: WIDTH];
                grant_c[i] = found & ~bus.hold & reset_L;
            end
        end
    end

    assign bus.grant = grant_c;

    // ---- stage p1: registered output and arbitration pointer ----
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr     <= '0;
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            sel_p1  <= '0;
        end else if (!bus.hold) begin
            if (found) begin
                data_p1 <= win_data;
                vld_p1  <= 1'b1;
                sel_p1  <= win_sel;
                if (MODE == 0) begin
                    ptr <= nxt_ptr;
                end
            end else begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.data_out  = data_p1;
    assign bus.valid_out = vld_p1;
    assign bus.sel_out   = sel_p1;

endmodule

// File: tb/tb_mux_rr_param.sv
// tb_mux_rr_param
//   Three instances: 4-channel round-robin, 4-channel fixed priority and
//   3-channel round-robin. Directed phases drive one instance with hand
//   computed expectations; a final random phase drives all three against a
//   behavioural model. Expected outputs go into per-instance queues that a
//   separate monitor drains one entry per clock.
module tb_mux_rr_param;

    typedef struct packed {
        logic       v;
        logic [3:0] d;
        logic [1:0] s;
    } exp_t;

    logic        clk;
    logic [2:0]  rstn;
    logic [3:0]  v_in   [3];
    logic        hold_v [3];
    logic [15:0] din    [3];
    logic [3:0]  g      [3];
    logic [3:0]  dout   [3];
    logic        vout   [3];
    logic [1:0]  sout   [3];

    int checks = 0;
    int errors = 0;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    mux_rr_param_if #(.WIDTH(4), .N_CH(4), .SEL_W(2)) if0 ();
    mux_rr_param_if #(.WIDTH(4), .N_CH(4), .SEL_W(2)) if1 ();
    mux_rr_param_if #(.WIDTH(4), .N_CH(3), .SEL_W(2)) if2 ();

    mux_rr_param #(.WIDTH(4), .N_CH(4), .SEL_W(2), .MODE(0)) dut_rr (
        .clk(clk), .reset_L(rstn[0]), .bus(if0.slave));
    mux_rr_param #(.WIDTH(4), .N_CH(4), .SEL_W(2), .MODE(1)) dut_fp (
        .clk(clk), .reset_L(rstn[1]), .bus(if1.slave));
    mux_rr_param #(.WIDTH(4), .N_CH(3), .SEL_W(2), .MODE(0)) dut_n3 (
        .clk(clk), .reset_L(rstn[2]), .bus(if2.slave));

    assign if0.data_in  = din[0];
    assign if0.valid_in = v_in[0];
    assign if0.hold     = hold_v[0];
    assign if1.data_in  = din[1];
    assign if1.valid_in = v_in[1];
    assign if1.hold     = hold_v[1];
    assign if2.data_in  = din[2][11:0];
    assign if2.valid_in = v_in[2][2:0];
    assign if2.hold     = hold_v[2];

    assign g[0] = if0.grant;
    assign g[1] = if1.grant;
    assign g[2] = {1'b0, if2.grant};
    assign dout[0] = if0.data_out;
    assign dout[1] = if1.data_out;
    assign dout[2] = if2.data_out;
    assign vout[0] = if0.valid_out;
    assign vout[1] = if1.valid_out;
    assign vout[2] = if2.valid_out;
    assign sout[0] = if0.sel_out;
    assign sout[1] = if1.sel_out;
    assign sout[2] = if2.sel_out;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input exp_t e);
        case (k)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    // Monitor: one registered output word per clock for every queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                logic have;
                have = 1'b0;
                case (k)
                    0: if (sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
                    1: if (sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
                    default: if (sb2.size() > 0) begin e = sb2.pop_front(); have = 1'b1; end
                endcase
                if (have)
                    chk($sformatf("out%0d{v,d,s}", k), {25'd0, vout[k], dout[k], sout[k]},
                        {25'd0, e.v, e.d, e.s});
            end
        end
    end

    // One clock for instance k: drive inputs, check grant mid-cycle,
    // queue the word expected after the coming edge.
    task automatic step(input int k, input logic [3:0] v, input logic h, input logic [15:0] d,
                        input logic [3:0] eg, input logic ev, input logic [3:0] ed,
                        input logic [1:0] es);
        exp_t e;
        v_in[k]   = v;
        hold_v[k] = h;
        din[k]    = d;
        @(negedge clk);
        chk($sformatf("grant%0d", k), {28'd0, g[k]}, {28'd0, eg});
        e = '{v: ev, d: ed, s: es};
        push(k, e);
        @(posedge clk);
        #2;
    endtask

    task automatic chk_cleared(input int k, input string tag);
        chk($sformatf("%s_grant%0d", tag, k), {28'd0, g[k]}, 32'd0);
        chk($sformatf("%s_out%0d", tag, k), {25'd0, vout[k], dout[k], sout[k]}, 32'd0);
    endtask

    int          nch  [3] = '{4, 4, 3};
    int          mmode[3] = '{0, 1, 0};
    int          mptr [3];
    exp_t        mout [3];

    initial begin
        logic [15:0] rd;
        rstn = 3'b000;
        for (int k = 0; k < 3; k++) begin
            v_in[k]   = 4'b1111;
            hold_v[k] = 1'b0;
            din[k]    = 16'($urandom);
        end
        @(posedge clk);
        #2;

        // Reset held with requests pending: nothing granted, outputs zero.
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 3; k++) din[k] = 16'($urandom);
            #1;
            chk_cleared(0, "rst");
            chk_cleared(1, "rst");
            @(posedge clk);
            #2;
        end
        rstn[0] = 1'b1;
        for (int c = 0; c < 2; c++)
            step(0, 4'b0000, 1'b0, 16'($urandom), 4'b0000, 1'b0, 4'h0, 2'd0);

        // Round-robin rotation over all four channels.
        step(0, 4'b1111, 1'b0, 16'hDCBA, 4'b0001, 1'b1, 4'hA, 2'd0);
        step(0, 4'b1111, 1'b0, 16'hDCBA, 4'b0010, 1'b1, 4'hB, 2'd1);
        step(0, 4'b1111, 1'b0, 16'hDCBA, 4'b0100, 1'b1, 4'hC, 2'd2);
        step(0, 4'b1111, 1'b0, 16'hDCBA, 4'b1000, 1'b1, 4'hD, 2'd3);
        step(0, 4'b1111, 1'b0, 16'hDCBA, 4'b0001, 1'b1, 4'hA, 2'd0);

        // Sparse requests on channels 1 and 3, then idle.
        step(0, 4'b1010, 1'b0, 16'hDCBA, 4'b0010, 1'b1, 4'hB, 2'd1);
        step(0, 4'b1010, 1'b0, 16'hDCBA, 4'b1000, 1'b1, 4'hD, 2'd3);
        step(0, 4'b1010, 1'b0, 16'hDCBA, 4'b0010, 1'b1, 4'hB, 2'd1);
        step(0, 4'b1010, 1'b0, 16'hDCBA, 4'b1000, 1'b1, 4'hD, 2'd3);
        step(0, 4'b0000, 1'b0, 16'hDCBA, 4'b0000, 1'b0, 4'hD, 2'd3);
        step(0, 4'b0000, 1'b0, 16'hDCBA, 4'b0000, 1'b0, 4'hD, 2'd3);

        // Hold mid-stream: output frozen, rotation resumes after last winner.
        step(0, 4'b1111, 1'b0, 16'hDCBA, 4'b0001, 1'b1, 4'hA, 2'd0);
        step(0, 4'b1111, 1'b0, 16'hDCBA, 4'b0010, 1'b1, 4'hB, 2'd1);
        step(0, 4'b1111, 1'b1, 16'h5678, 4'b0000, 1'b1, 4'hB, 2'd1);
        step(0, 4'b0101, 1'b1, 16'h5678, 4'b0000, 1'b1, 4'hB, 2'd1);
        step(0, 4'b1111, 1'b1, 16'h5678, 4'b0000, 1'b1, 4'hB, 2'd1);
        step(0, 4'b1111, 1'b0, 16'hDCBA, 4'b0100, 1'b1, 4'hC, 2'd2);
        step(0, 4'b1111, 1'b0, 16'hDCBA, 4'b1000, 1'b1, 4'hD, 2'd3);
        v_in[0] = 4'b0000;

        // Fixed priority: lowest requesting index always wins.
        rstn[1] = 1'b1;
        step(1, 4'b1110, 1'b0, 16'hDCBA, 4'b0010, 1'b1, 4'hB, 2'd1);
        step(1, 4'b1110, 1'b0, 16'hDCBA, 4'b0010, 1'b1, 4'hB, 2'd1);
        step(1, 4'b1110, 1'b0, 16'hDCBA, 4'b0010, 1'b1, 4'hB, 2'd1);
        step(1, 4'b1111, 1'b0, 16'hDCBA, 4'b0001, 1'b1, 4'hA, 2'd0);
        step(1, 4'b1111, 1'b0, 16'hDCBA, 4'b0001, 1'b1, 4'hA, 2'd0);
        v_in[1] = 4'b0000;

        // Three channels: index wraps 2 -> 0, never 3.
        rstn[2] = 1'b1;
        step(2, 4'b1111, 1'b0, 16'hFCBA, 4'b0001, 1'b1, 4'hA, 2'd0);
        step(2, 4'b1111, 1'b0, 16'hFCBA, 4'b0010, 1'b1, 4'hB, 2'd1);
        step(2, 4'b1111, 1'b0, 16'hFCBA, 4'b0100, 1'b1, 4'hC, 2'd2);
        step(2, 4'b1111, 1'b0, 16'hFCBA, 4'b0001, 1'b1, 4'hA, 2'd0);
        step(2, 4'b1111, 1'b0, 16'hFCBA, 4'b0010, 1'b1, 4'hB, 2'd1);

        // Reset pulse between edges clears at once; restart from channel 0.
        #2;
        rstn[2] = 1'b0;
        #2;
        chk_cleared(2, "midrst");
        #2;
        rstn[2] = 1'b1;
        step(2, 4'b1111, 1'b0, 16'hFCBA, 4'b0001, 1'b1, 4'hA, 2'd0);
        step(2, 4'b1111, 1'b0, 16'hFCBA, 4'b0010, 1'b1, 4'hB, 2'd1);

        // Random phase against the behavioural model, all instances together.
        rstn = 3'b000;
        #2;
        rstn = 3'b111;
        for (int k = 0; k < 3; k++) begin
            mptr[k] = 0;
            mout[k] = '0;
        end
        for (int c = 0; c < 10000; c++) begin
            logic [3:0] rv;
            logic       rh;
            rv = 4'($urandom);
            rh = ($urandom_range(0, 4) == 0);
            rd = 16'($urandom);
            for (int k = 0; k < 3; k++) begin
                v_in[k]   = rv;
                hold_v[k] = rh;
                din[k]    = rd;
            end
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                int         w;
                int         st;
                logic [3:0] eg;
                w  = -1;
                st = (mmode[k] == 1) ? 0 : mptr[k];
                for (int j = 0; j < nch[k]; j++) begin
                    int cc;
                    cc = (st + j) % nch[k];
                    if (w < 0 && (((rv >> cc) & 4'd1) == 4'd1)) w = cc;
                end
                eg = (!rh && w >= 0) ? (4'b0001 << w) : 4'b0000;
                chk($sformatf("rnd_grant%0d", k), {28'd0, g[k]}, {28'd0, eg});
                if (!rh) begin
                    if (w >= 0) begin
                        mout[k].v = 1'b1;
                        mout[k].d = 4'((rd >> (4 * w)) & 16'hF);
                        mout[k].s = 2'(w);
                        mptr[k]   = (mmode[k] == 1) ? 0 : (w + 1) % nch[k];
                    end else begin
                        mout[k].v = 1'b0;
                    end
                end
                push(k, mout[k]);
            end
            @(posedge clk);
            #2;
        end

        @(posedge clk);
        #2;
        chk("sb_drain", 32'(sb0.size() + sb1.size() + sb2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_param.md
Name: mux_rr_param

Overview:
- Parametrised registered N-channel multiplexer; successor to the 2-input, 4-bit registered mux.
- Selects one valid input channel per cycle using round-robin or fixed-priority arbitration.
- Registers the selected data with a valid flag and the source index.
- Returns a one-hot grant so upstream sources can dequeue, and honours a downstream hold (stall).

Parameters:
- WIDTH, 4, bits per data channel.
- N_CH, 4, number of input channels; legal range 2..16, need not be a power of two.
- SEL_W, 2, width of the index/pointer; must satisfy 2**SEL_W >= N_CH.
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  input  1  rising-edge clock.
- reset_L  input  1  asynchronous, active-low reset.
- data_in  input  N_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- valid_in  input  N_CH  per-channel request; bit i qualifies channel i.
- hold  input  1  downstream stall; while 1, all registers freeze.
- data_out  output  WIDTH  registered selected data.
- valid_out  output  1  registered; 1 when data_out was loaded on the last non-held edge.
- sel_out  output  SEL_W  registered index of the channel that produced data_out.
- grant  output  N_CH  combinational one-hot; channel accepted this cycle.

Behaviour:
- Reset: reset_L=0 clears immediately, without waiting for clk.
  - data_out=0, valid_out=0, sel_out=0, internal pointer ptr=0.
  - grant=0 while reset_L=0.
- Reset asserted mid-stream drops any in-flight word; no grant is issued during reset.
- Arbitration (combinational, each cycle), search start point:
  - MODE=0: search starts at ptr and scans ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1.
  - MODE=1: search always starts at 0.
- First channel found with valid_in=1 is the winner idx.
- grant: one-hot bit idx set when hold=0, reset_L=1 and any valid_in=1; otherwise all zero.
  - Never more than one bit set.
- Rising edge, hold=0, winner exists:
  - data_out <= data_in[idx], valid_out <= 1, sel_out <= idx.
  - MODE=0: ptr <= idx+1, wrapping to 0 when idx = N_CH-1.
  - MODE=1: ptr stays 0.
- Rising edge, hold=0, no valid_in:
  - valid_out <= 0; data_out and sel_out keep their previous values; ptr unchanged.
- Rising edge, hold=1:
  - data_out, valid_out, sel_out and ptr unchanged; grant=0, so no channel is consumed.
- Latency: one clock from grant to the data on data_out/valid_out.
  - Throughput: one word per cycle while hold=0.
- Fairness (MODE=0): with K channels continuously valid, each is granted exactly once every K cycles.
  - The most recent winner has lowest priority on the next cycle.
- Non-power-of-two N_CH:
  - ptr and sel_out never take values >= N_CH.
  - data_in bits above N_CH*WIDTH do not exist; no out-of-range channel is indexed.
- Simultaneous hold=1 and valid_in change: the edge is ignored entirely; arbitration resumes from the same ptr once hold falls.
- valid_in bits may change freely between cycles; only the values present at the clock edge matter.
- No X propagation: data_out never loads from an unselected channel.

Test Plan:
- Reset then idle: reset_L=0 for 2 cycles with random data_in -> data_out=0, valid_out=0, sel_out=0, grant=0; release with valid_in=0 -> outputs stay 0.
- Round-robin fairness, N_CH=4, WIDTH=4, MODE=0, valid_in=4'b1111, data ch0..3 = 0xA, 0xB, 0xC, 0xD:
  - grant sequence 0001, 0010, 0100, 1000, 0001.
  - data_out sequence A, B, C, D, A, one cycle later, valid_out=1 throughout.
- Sparse requests, MODE=0, valid_in=4'b1010:
  - winners alternate 1, 3, 1, 3; sel_out matches one cycle later.
  - Dropping valid_in to 0 -> valid_out=0 next cycle, data_out holds its last value.
- Hold behaviour: mid-stream, assert hold for 3 cycles -> grant=0 and data_out/sel_out/valid_out frozen; on release, arbitration continues at the channel after the last winner.
- Fixed priority, MODE=1, valid_in=4'b1110 then 4'b1111: winners 1, 1, 1, then 0, 0 -> lowest index always wins.
- Non-power-of-two and reset mid-op, N_CH=3, SEL_W=2, all valid:
  - sel_out cycles 0, 1, 2, 0 and never reaches 3.
  - Pulse reset_L low between clock edges -> outputs clear immediately; first winner after release is channel 0.
- Compare against a behavioural reference model in the bench over 10k random cycles of valid_in/hold/data_in for each MODE -> zero mismatches.
